// File: rtl/l2_arbiter_if.sv
// ============================================================================
//  Module      : l2_arbiter_if
//  Description : I-cache, D-cache and L2 line-request bus bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface l2_arbiter_if #(
    parameter int s_line = 256
);
    logic              i_mem_read;
    logic [31:0]       i_mem_address;
    logic [s_line-1:0] i_mem_rdata;
    logic              i_mem_resp;

    logic              d_mem_read;
    logic              d_mem_write;
    logic [31:0]       d_mem_address;
    logic [s_line-1:0] d_mem_wdata;
    logic [s_line-1:0] d_mem_rdata;
    logic              d_mem_resp;

    logic              l2_read;
    logic              l2_write;
    logic [31:0]       l2_address;
    logic [s_line-1:0] l2_wdata;
    logic [s_line-1:0] l2_rdata;
    logic              l2_resp;

    // Arbiter side
    modport slave (
        input  i_mem_read, i_mem_address,
        input  d_mem_read, d_mem_write, d_mem_address, d_mem_wdata,
        input  l2_rdata, l2_resp,
        output i_mem_rdata, i_mem_resp,
        output d_mem_rdata, d_mem_resp,
        output l2_read, l2_write, l2_address, l2_wdata
    );

    // Clients and L2 side
    modport master (
        output i_mem_read, i_mem_address,
        output d_mem_read, d_mem_write, d_mem_address, d_mem_wdata,
        output l2_rdata, l2_resp,
        input  i_mem_rdata, i_mem_resp,
        input  d_mem_rdata, d_mem_resp,
        input  l2_read, l2_write, l2_address, l2_wdata
    );
endinterface

`default_nettype wire

// File: rtl/l2_arbiter.sv
// ============================================================================
//  Module      : l2_arbiter
//  Description : Round-robin arbiter sharing one L2 port between I and D caches.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module l2_arbiter #(
    parameter int s_line   = 256,
    parameter int s_offset = 5
) (
    input  logic         clk,
    input  logic         rst,
    l2_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    localparam logic [31:0] c_addr_mask = ~((32'd1 << s_offset) - 32'd1);

    state_t            r_state;
    state_t            w_next_state;
    logic              r_last_grant;
    logic [31:0]       r_addr;
    logic              r_write;
    logic [s_line-1:0] r_wdata;

    logic              w_i_req;
    logic              w_d_req;
    logic              w_grant;
    logic              w_grant_d;

    assign w_i_req   = bus.i_mem_read;
    assign w_d_req   = bus.d_mem_read | bus.d_mem_write;
    assign w_grant   = (r_state == IDLE) && (w_i_req || w_d_req);
    // On a tie the client that did not win last time goes first
    assign w_grant_d = w_d_req && (!w_i_req || !r_last_grant);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b0;
            r_addr       <= 32'd0;
            r_write      <= 1'b0;
            r_wdata      <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_grant) begin
                r_last_grant <= w_grant_d;
                r_addr       <= (w_grant_d ? bus.d_mem_address : bus.i_mem_address) & c_addr_mask;
                r_write      <= w_grant_d & bus.d_mem_write;
                r_wdata      <= bus.d_mem_wdata;
            end
        end
    end

    always_comb begin
        w_next_state   = r_state;
        bus.l2_read    = 1'b0;
        bus.l2_write   = 1'b0;
        bus.l2_address = 32'd0;
        bus.l2_wdata   = '0;
        bus.i_mem_resp = 1'b0;
        bus.d_mem_resp = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_next_state = w_grant_d ? SERVE_D : SERVE_I;
                end
            end
            SERVE_I: begin
                bus.l2_read    = 1'b1;
                bus.l2_address = r_addr;
                bus.l2_wdata   = r_wdata;
                if (bus.l2_resp) begin
                    bus.i_mem_resp = 1'b1;
                    w_next_state   = IDLE;
                end
            end
            SERVE_D: begin
                bus.l2_read    = !r_write;
                bus.l2_write   = r_write;
                bus.l2_address = r_addr;
                bus.l2_wdata   = r_wdata;
                if (bus.l2_resp) begin
                    bus.d_mem_resp = 1'b1;
                    w_next_state   = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Read data is a straight pass-through; resp is the only qualifier
    assign bus.i_mem_rdata = bus.l2_rdata;
    assign bus.d_mem_rdata = bus.l2_rdata;

endmodule

`default_nettype wire
